// File: rtl/updn_counter_mod.sv
// ---------------------------------------------------------------------------
// updn_counter_mod
// Parametrised up/down counter with count enable, synchronous load (clamped
// to MAX), and a runtime-selectable wrap (modulo MAX+1) or saturate mode.
// Registered one-cycle wrap / sat_hit event pulses, combinational boundary
// decodes derived from the registered count.
//
// Parameters:
//   WIDTH : count register width, 1..32
//   MAX   : terminal count, 1..2**WIDTH-1; sequence is 0..MAX
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   en         in   count enable
//   up_down    in   1 = count up, 0 = count down
//   sat_mode   in   1 = saturate at the boundaries, 0 = wrap
//   load       in   synchronous load strobe (beats en)
//   load_val   in   value to load, clamped to MAX
//   count      out  registered count
//   at_max     out  count == MAX
//   at_min     out  count == 0
//   wrap       out  pulse: the count wrapped on the previous edge
//   sat_hit    out  pulse: a step was blocked by saturation on the previous edge
//
// Optional build macro UPDN_COUNTER_STICKY_EN adds:
//   flag_clr   in   clears the sticky flags (a coincident set wins)
//   ovf_sticky out  set by a wrap or saturation at MAX while counting up
//   unf_sticky out  set by a wrap or saturation at 0 while counting down
// ---------------------------------------------------------------------------
module updn_counter_mod #(
  parameter int          WIDTH = 3,
  parameter int unsigned MAX   = (32'd1 << WIDTH) - 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UPDN_COUNTER_STICKY_EN
  input  logic             flag_clr,
  output logic             ovf_sticky,
  output logic             unf_sticky,
`endif
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_r;
  logic             wrap_nxt_s;
  logic             sat_r;
  logic             sat_nxt_s;
`ifdef UPDN_COUNTER_STICKY_EN
  logic             ovf_r;
  logic             unf_r;
  logic             ovf_set_s;
  logic             unf_set_s;
`endif

  // Next count and event pulses; load beats enable, wrap is explicit at MAX.
  always_comb begin
    count_nxt_s = count_r;
    wrap_nxt_s  = 1'b0;
    sat_nxt_s   = 1'b0;
`ifdef UPDN_COUNTER_STICKY_EN
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
`endif
    if (load) begin
      count_nxt_s = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (up_down) begin
        if (count_r == MAX_V) begin
`ifdef UPDN_COUNTER_STICKY_EN
          ovf_set_s = 1'b1;
`endif
          if (sat_mode) begin
            sat_nxt_s = 1'b1;
          end else begin
            count_nxt_s = ZERO_V;
            wrap_nxt_s  = 1'b1;
          end
        end else begin
          count_nxt_s = count_r + ONE_V;
        end
      end else begin
        if (count_r == ZERO_V) begin
`ifdef UPDN_COUNTER_STICKY_EN
          unf_set_s = 1'b1;
`endif
          if (sat_mode) begin
            sat_nxt_s = 1'b1;
          end else begin
            count_nxt_s = MAX_V;
            wrap_nxt_s  = 1'b1;
          end
        end else begin
          count_nxt_s = count_r - ONE_V;
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count and event pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= ZERO_V;
      wrap_r  <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      wrap_r  <= wrap_nxt_s;
      sat_r   <= sat_nxt_s;
    end
  end

`ifdef UPDN_COUNTER_STICKY_EN
  // Sticky boundary flags; a set on the same edge as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_set_s | (ovf_r & ~flag_clr);
      unf_r <= unf_set_s | (unf_r & ~flag_clr);
    end
  end

  assign ovf_sticky = ovf_r;
  assign unf_sticky = unf_r;
`endif

  assign count   = count_r;
  assign wrap    = wrap_r;
  assign sat_hit = sat_r;
  assign at_max  = (count_r == MAX_V);
  assign at_min  = (count_r == ZERO_V);

endmodule

// File: tb/tb_updn_counter_mod.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for updn_counter_mod. Two instances: dut_a (WIDTH=3,
// MAX=7) and dut_b (WIDTH=3, MAX=5). Stimulus drives on the falling edge and
// pushes the hand-computed response into a per-instance queue; a monitor
// pops and compares just after each rising edge.
// ---------------------------------------------------------------------------
module tb_updn_counter_mod;

  typedef struct packed {
    logic [2:0] cnt;
    logic       wrap;
    logic       sat;
    logic       amax;
    logic       amin;
    logic       chk_st;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en_a = 1'b0, ud_a = 1'b0, sat_a = 1'b0, load_a = 1'b0;
  logic [2:0] lv_a = 3'd0;
  logic       en_b = 1'b0, ud_b = 1'b0, sat_b = 1'b0, load_b = 1'b0;
  logic [2:0] lv_b = 3'd0;
  logic [2:0] count_a, count_b;
  logic       at_max_a, at_min_a, wrap_a, sat_hit_a;
  logic       at_max_b, at_min_b, wrap_b, sat_hit_b;
`ifdef UPDN_COUNTER_STICKY_EN
  logic       flag_clr_a = 1'b0, flag_clr_b = 1'b0;
  logic       ovf_a, unf_a, ovf_b, unf_b;
`endif

  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  updn_counter_mod #(.WIDTH(3), .MAX(7)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .up_down(ud_a), .sat_mode(sat_a),
    .load(load_a), .load_val(lv_a),
`ifdef UPDN_COUNTER_STICKY_EN
    .flag_clr(flag_clr_a), .ovf_sticky(ovf_a), .unf_sticky(unf_a),
`endif
    .count(count_a), .at_max(at_max_a), .at_min(at_min_a),
    .wrap(wrap_a), .sat_hit(sat_hit_a)
  );

  updn_counter_mod #(.WIDTH(3), .MAX(5)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .up_down(ud_b), .sat_mode(sat_b),
    .load(load_b), .load_val(lv_b),
`ifdef UPDN_COUNTER_STICKY_EN
    .flag_clr(flag_clr_b), .ovf_sticky(ovf_b), .unf_sticky(unf_b),
`endif
    .count(count_b), .at_max(at_max_b), .at_min(at_min_b),
    .wrap(wrap_b), .sat_hit(sat_hit_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per instance per rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_step", {count_a, wrap_a, sat_hit_a, at_max_a, at_min_a},
          {e.cnt, e.wrap, e.sat, e.amax, e.amin});
`ifdef UPDN_COUNTER_STICKY_EN
      if (e.chk_st) chk("a_sticky", {ovf_a, unf_a}, {e.ovf, e.unf});
`endif
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_step", {count_b, wrap_b, sat_hit_b, at_max_b, at_min_b},
          {e.cnt, e.wrap, e.sat, e.amax, e.amin});
    end
  end

  task automatic step_a(input logic e, input logic ud, input logic s, input logic ld,
                        input logic [2:0] lv, input logic [2:0] xc,
                        input logic xw, input logic xs);
    @(negedge clk);
    en_a = e; ud_a = ud; sat_a = s; load_a = ld; lv_a = lv;
`ifdef UPDN_COUNTER_STICKY_EN
    flag_clr_a = 1'b0;
`endif
    qa.push_back('{cnt: xc, wrap: xw, sat: xs, amax: (xc == 3'd7), amin: (xc == 3'd0),
                   chk_st: 1'b0, ovf: 1'b0, unf: 1'b0});
  endtask

  task automatic step_b(input logic e, input logic ud, input logic s, input logic ld,
                        input logic [2:0] lv, input logic [2:0] xc,
                        input logic xw, input logic xs);
    @(negedge clk);
    en_b = e; ud_b = ud; sat_b = s; load_b = ld; lv_b = lv;
    qb.push_back('{cnt: xc, wrap: xw, sat: xs, amax: (xc == 3'd5), amin: (xc == 3'd0),
                   chk_st: 1'b0, ovf: 1'b0, unf: 1'b0});
  endtask

`ifdef UPDN_COUNTER_STICKY_EN
  task automatic step_a_st(input logic e, input logic ud, input logic clr,
                           input logic [2:0] xc, input logic xw,
                           input logic xo, input logic xu);
    @(negedge clk);
    en_a = e; ud_a = ud; sat_a = 1'b0; load_a = 1'b0; lv_a = 3'd0; flag_clr_a = clr;
    qa.push_back('{cnt: xc, wrap: xw, sat: 1'b0, amax: (xc == 3'd7), amin: (xc == 3'd0),
                   chk_st: 1'b1, ovf: xo, unf: xu});
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("por_a", {count_a, wrap_a, sat_hit_a, at_min_a}, {3'd0, 1'b0, 1'b0, 1'b1});
    chk("por_b", {count_b, wrap_b, sat_hit_b, at_min_b}, {3'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    reset = 1'b0;

    // A: count up 0..5, then async reset mid-count.
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_reset", {count_a, wrap_a, sat_hit_a, at_min_a, at_max_a},
        {3'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    #2;
    chk("reset_held", {count_a, at_min_a}, {3'd0, 1'b1});
    @(negedge clk);
    reset = 1'b0;
    en_a = 1'b0;

    // A: down saturate from a load of 2.
    step_a(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    step_a(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
    // A: down wrap 0 -> 7, up saturate at 7, up wrap 7 -> 0.
    step_a(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 1'b1, 1'b0);
    step_a(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1);
    step_a(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    step_a(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

    // B (MAX=5): up wrap over 7 edges.
    step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
    step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0);
    step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0);
    step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0);
    step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 1'b0);
    step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0);
    // B: load beats enable and clamps 7 to 5; then wrap up.
    step_b(1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 3'd5, 1'b0, 1'b0);
    step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0);
    // B: enable / direction from 3.
    step_b(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0);
    step_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0);
    step_b(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0);
    step_b(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd3, 1'b0, 1'b0);
    // B: down wrap 0 -> 5, up saturate at 5, in-range load.
    step_b(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0);
    step_b(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 1'b0);
    step_b(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd5, 1'b0, 1'b1);
    step_b(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 3'd4, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0);

`ifdef UPDN_COUNTER_STICKY_EN
    // Sticky flags: start clean from reset.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step_a_st(1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step_a_st(1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1);
    step_a_st(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
    step_a_st(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
`endif

    @(negedge clk);
    en_a = 1'b0; load_a = 1'b0; en_b = 1'b0; load_b = 1'b0;
    @(negedge clk);
    chk("queues_drained", qa.size() + qb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updn_counter_mod.md
Name: updn_counter_mod

Overview:
Parametrised up/down counter. Width and modulus are set by parameters. Adds count enable, synchronous load, and a runtime-selectable wrap or saturate mode. Emits registered wrap and saturation event pulses plus boundary decodes. Serves as the general-purpose counter for lab datapaths: timers, position counters and address walkers.

Parameters:
WIDTH, 3, count register width in bits; legal range 1..32
MAX, 2**WIDTH-1, terminal (largest) count value; legal range 1..2**WIDTH-1; the counter sequence is 0..MAX

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  count enable; counts one step per clock while high
up_down  input  1  direction: 1 = up (+1), 0 = down (-1)
sat_mode  input  1  boundary mode: 1 = saturate, 0 = wrap (modulo MAX+1)
load  input  1  synchronous load strobe
load_val  input  WIDTH  value to load; clamped to MAX
count  output  WIDTH  current count, registered
at_max  output  1  combinational: count == MAX
at_min  output  1  combinational: count == 0
wrap  output  1  registered one-cycle pulse; the count wrapped on the previous edge
sat_hit  output  1  registered one-cycle pulse; a step was blocked by saturation on the previous edge

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (async, any time, including mid-count or during load): count=0, wrap=0, sat_hit=0. Outputs stay held while reset is high. The first step happens on the first rising edge after reset deasserts.
- Priority per edge: reset > load > en > hold.
- load=1: count <= (load_val > MAX) ? MAX : load_val. wrap=0 and sat_hit=0 on that edge. en and up_down are ignored.
- en=0, load=0: count holds; wrap=0, sat_hit=0.
- en=1, up_down=1:
  - count<MAX: count+1.
  - count==MAX, sat_mode=0: count <= 0, wrap <= 1.
  - count==MAX, sat_mode=1: count holds at MAX, sat_hit <= 1.
- en=1, up_down=0:
  - count>0: count-1.
  - count==0, sat_mode=0: count <= MAX, wrap <= 1.
  - count==0, sat_mode=1: count holds at 0, sat_hit <= 1.
- Latency: count, wrap and sat_hit all update on the same edge as the step. at_max/at_min follow count with zero added latency.
- Arithmetic: comparisons and steps are done at WIDTH bits. Modulus wrap is explicit at MAX, never a natural binary overflow, so non-power-of-2 MAX works.
- Direction or mode changes take effect on the very next enabled edge; there is no hysteresis.
- A count value above MAX is unreachable; no recovery logic is required.
- Edge case MAX=1, WIDTH=1: sequence 0,1,0,... with wrap on every second step in each direction.

Optional Feature:
Macro UPDN_COUNTER_STICKY_EN.
- Defined:
  - Adds input flag_clr (1 bit) and outputs ovf_sticky and unf_sticky (1 bit each, registered, reset 0).
  - ovf_sticky sets on any edge where the counter wraps or saturates at MAX going up.
  - unf_sticky sets on any edge where the counter wraps or saturates at 0 going down.
  - Both stay set until flag_clr=1 on a clock edge.
  - If set and clear occur on the same edge, set wins.
  - Both flags clear on reset.
- Not defined: these ports and registers do not exist. Core behaviour is identical either way.

Test Plan:
1. Reset/hold: WIDTH=3, MAX=7; assert reset mid-count at count=5 -> count=0 immediately with no clock edge, wrap=0, sat_hit=0, at_min=1.
2. Up wrap, non-power-of-2: MAX=5, sat_mode=0, en=1, up=1 for 7 edges from 0 -> 1,2,3,4,5,0,1; wrap=1 only in the cycle after 5->0.
3. Down saturate: MAX=7, sat_mode=1, load 2 then down for 4 edges -> 1,0,0,0; sat_hit=1 after the 3rd and 4th edges; at_min=1 from count 0 on.
4. Load priority and clamp: MAX=5, en=1, up=1, load=1, load_val=7 -> count=5 (not 6 or 0), wrap=0; next edge with load=0, sat_mode=0 -> count=0, wrap=1.
5. Enable and direction: en toggled 1,0,1 with up_down 1,1,0 from count 3 -> 4,4,3; no pulses.
6. With UPDN_COUNTER_STICKY_EN: wrap down 0->MAX -> unf_sticky=1, which persists across 10 edges; flag_clr=1 coincident with an up wrap -> ovf_sticky=1, unf_sticky=0.
